// File: rtl/mac_z_pkg.sv
// mac_z_pkg: widths and state encoding shared by the mac_z / div_z pair.
package mac_z_pkg;
    localparam int MAC_M = 25;
    localparam int MAC_N = 8;
    localparam int MAC_W = MAC_M + MAC_N + 3;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/mac_z.sv
// mac_z: shift-add multiply-accumulate rebuilding did = quo*div + rem in N+1 clocks.
module mac_z
    import mac_z_pkg::*;
#(
    parameter int M = MAC_M,
    parameter int N = MAC_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M:0]     quo,
    input  logic [N:0]     div,
    input  logic [M:0]     rem,
    output logic           busy,
    output logic           done,
    output logic [M+N+2:0] did,
    output logic           ovf,
    output logic           error
);
    localparam int W  = M + N + 3;
    localparam int CW = $clog2(N + 2);

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d, mcand_q, mcand_d, did_q, did_d, sum;
    logic [N:0]    mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d, ovf_q, ovf_d, err_q, err_d;
    logic          accept, run, last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            did_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            did_q    <= did_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    always_comb begin
        accept   = (state_q == IDLE) && start;
        run      = (state_q == RUN);
        last     = (cnt_q == CW'(N));
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = accept ? W'(rem) : run ? sum : acc_q;
        mcand_d  = accept ? W'(quo) : run ? mcand_q << 1 : mcand_q;
        mplier_d = accept ? div : run ? mplier_q >> 1 : mplier_q;
        cnt_d    = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
        // error judges the triplet as a divider result; computation proceeds regardless
        err_d    = accept ? ((div == '0) || (W'(rem) >= W'(div))) : err_q;
        ovf_d    = accept ? 1'b0 : (run && last) ? |sum[W-1:M+1] : ovf_q;
        did_d    = (run && last) ? sum : did_q;
        done_d   = run && last;
        busy     = run;
        done     = done_q;
        did      = did_q;
        ovf      = ovf_q;
        error    = err_q;
    end
endmodule

// File: tb/tb_mac_z.sv
// tb_mac_z: randomized and directed checks of mac_z against an arithmetic reference.
module tb_mac_z;
    localparam int LAT = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [25:0] quo = '0, rem = '0;
    logic [8:0]  div = '0;
    logic        busy, done, ovf, error;
    logic [35:0] did;

    int total = 0, bad = 0;

    bit          free = 1'b1;
    int          left = 0;
    logic [63:0] pend = '0, exp_did = '0;
    bit          exp_ovf = 1'b0, exp_err = 1'b0, exp_done = 1'b0;

    mac_z dut (
        .clk(clk), .rst(rst), .start(start), .quo(quo), .div(div), .rem(rem),
        .busy(busy), .done(done), .did(did), .ovf(ovf), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        free = 1'b1; left = 0; pend = '0; exp_did = '0;
        exp_ovf = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
    endtask

    task automatic check_all(input string where);
        chk({where, ":busy"}, 64'(busy), 64'(!free));
        chk({where, ":done"}, 64'(done), 64'(exp_done));
        chk({where, ":did"}, 64'(did), exp_did);
        chk({where, ":ovf"}, 64'(ovf), 64'(exp_ovf));
        chk({where, ":error"}, 64'(error), 64'(exp_err));
    endtask

    // Drive one cycle of inputs, clock once, advance the reference, compare everything.
    task automatic step(input string where, input logic s, input logic [25:0] q,
                        input logic [8:0] d, input logic [25:0] r);
        start = s; quo = q; div = d; rem = r;
        @(posedge clk);
        exp_done = 1'b0;
        if (free && s) begin
            pend    = 64'(q) * 64'(d) + 64'(r);
            exp_err = (d == 0) || (r >= 26'(d));
            exp_ovf = 1'b0;
            free    = 1'b0;
            left    = LAT;
        end else if (!free) begin
            left--;
            if (left == 0) begin
                exp_did  = pend;
                exp_ovf  = pend >= 64'(1) << 26;
                exp_done = 1'b1;
                free     = 1'b1;
            end
        end
        #1;
        check_all(where);
    endtask

    task automatic op(input string where, input logic [25:0] q, input logic [8:0] d,
                      input logic [25:0] r);
        step(where, 1'b1, q, d, r);
        for (int i = 0; i < LAT + 1; i++) step(where, 1'b0, 26'($urandom), 9'($urandom), 26'($urandom));
    endtask

    task automatic rnd_op(output logic [25:0] q, output logic [8:0] d, output logic [25:0] r);
        q = ($urandom_range(0, 3) == 0) ? 26'($urandom_range(0, 100)) : 26'($urandom);
        d = 9'($urandom);
        r = ($urandom_range(0, 1) == 0) ? 26'($urandom_range(0, 600)) : 26'($urandom);
    endtask

    initial begin
        logic [25:0] q, r;
        logic [8:0]  d;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        check_all("post_reset");

        op("basic", 26'd1000, 9'd7, 26'd3);
        chk("basic_val", 64'(did), 64'd7003);
        op("div0", 26'd12345, 9'd0, 26'd5);
        chk("div0_val", 64'(did), 64'd5);
        op("rem_eq", 26'd10, 9'd7, 26'd7);
        chk("rem_eq_val", 64'(did), 64'd77);
        op("max", 26'h3ffffff, 9'd511, 26'd510);
        chk("max_val", 64'(did), 64'd34292629503);
        chk("max_ovf", 64'(ovf), 64'd1);

        // start pulses mid-operation must be ignored
        step("ign", 1'b1, 26'd3, 9'd4, 26'd1);
        for (int i = 0; i < LAT + 2; i++) begin
            rnd_op(q, d, r);
            step("ign", (i < LAT - 1) ? 1'($urandom) : 1'b0, q, d, r);
        end

        for (int i = 0; i < 40; i++) begin
            rnd_op(q, d, r);
            op("rand", q, d, r);
        end

        // start held high with fresh operands every cycle
        for (int i = 0; i < 60; i++) begin
            rnd_op(q, d, r);
            step("b2b", 1'b1, q, d, r);
        end
        for (int i = 0; i < LAT + 1; i++) step("b2b_drain", 1'b0, '0, '0, '0);

        // asynchronous reset four cycles into an operation
        step("abort", 1'b1, 26'd999, 9'd3, 26'd2);
        for (int i = 0; i < 4; i++) step("abort", 1'b0, '0, '0, '0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step("after_abort", 1'b0, '0, '0, '0);
        op("restart", 26'd50, 9'd9, 26'd8);
        chk("restart_val", 64'(did), 64'd458);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
